// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter slice.
//   ramstate_t  : RAM handshake state seen on the ramstate input.
//   arb_state_t : arbiter FSM states.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IACC   = 3'd1,
    DACC   = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } arb_state_t;

  localparam int DSTREAK_MAX_DEF = 4;
  localparam int RETRY_MAX_DEF   = 3;
  localparam int ADDR_W_DEF      = 32;
  localparam int WORD_W          = 32;

endpackage

// File: rtl/arb_fairness.sv
// Fairness counter and grant select for the memory arbiter.
// Ports:
//   CLK, RST   : clock, synchronous active-high reset
//   iREN       : instruction request pending
//   dreq       : data request pending (read or write)
//   grant_evt  : a grant is being made this cycle
//   grant_i    : 1 = the grant goes to instruction, 0 = to data
module arb_fairness #(
  parameter int DSTREAK_MAX = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic iREN,
  input  logic dreq,
  input  logic grant_evt,
  output logic grant_i
);

  localparam int SW = $clog2(DSTREAK_MAX + 1);

  logic [SW-1:0] streak;
  logic          at_limit;

  assign at_limit = (streak >= SW'(DSTREAK_MAX));

  // Data wins unless the streak is exhausted while an instruction waits.
  // The streak only grows while iREN is high, so a data-only request is
  // never blocked by a stale limit.
  assign grant_i = iREN && (!dreq || at_limit);

  always_ff @(posedge CLK) begin
    if (RST) begin
      streak <= '0;
    end else if (grant_evt) begin
      if (grant_i || !iREN) begin
        streak <= '0;
      end else begin
        streak <= streak + SW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sequencing a single-port RAM between instruction fetch and data.
// Ports:
//   CLK, RST                 : clock, synchronous active-high reset
//   iREN, iaddr              : instruction read request / address
//   iwait, iload             : instruction wait (low one cycle on done) / word
//   dREN, dWEN, daddr, dstore: data request (write wins), address, write data
//   dwait, dload             : data wait (low one cycle on done) / read data
//   ramREN, ramWEN           : registered RAM strobes
//   ramaddr, ramstore        : registered RAM address / write data
//   ramload, ramstate        : RAM read data / handshake state
//   err                      : sticky error after retries are exhausted
//
// state  | meaning
// IDLE   | no access; pick next requester, strobes low
// IACC   | instruction access in flight at RAM
// DACC   | data access in flight at RAM
// DONE_I | instruction complete, iwait low this cycle
// DONE_D | data complete, dwait low this cycle
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int DSTREAK_MAX = DSTREAK_MAX_DEF,
  parameter int RETRY_MAX   = RETRY_MAX_DEF,
  parameter int ADDR_W      = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              err
);

  localparam int RW = $clog2(RETRY_MAX + 1);

  arb_state_t state, state_n;
  ramstate_t  rs;

  logic              dreq, grant_evt, grant_i, req_live;
  logic              dwr, dwr_n;
  logic [RW-1:0]     retry, retry_n;
  logic              ren_n, wen_n, err_n;
  logic [ADDR_W-1:0] addr_n;
  logic [WORD_W-1:0] store_n, iload_n, dload_n;

  assign rs        = ramstate_t'(ramstate);
  assign dreq      = dREN | dWEN;
  assign grant_evt = (state == IDLE) && (iREN || dreq);

  arb_fairness #(
    .DSTREAK_MAX(DSTREAK_MAX)
  ) u_fair (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .dreq     (dreq),
    .grant_evt(grant_evt),
    .grant_i  (grant_i)
  );

  assign req_live = (state == IACC) ? iREN : dreq;

  assign iwait = (state != DONE_I);
  assign dwait = (state != DONE_D);

  always_comb begin
    state_n = state;
    ren_n   = ramREN;
    wen_n   = ramWEN;
    addr_n  = ramaddr;
    store_n = ramstore;
    iload_n = iload;
    dload_n = dload;
    retry_n = retry;
    err_n   = err;
    dwr_n   = dwr;

    case (state)
      IDLE: begin
        ren_n   = 1'b0;
        wen_n   = 1'b0;
        retry_n = '0;
        if (grant_evt) begin
          if (grant_i) begin
            state_n = IACC;
            ren_n   = 1'b1;
            addr_n  = iaddr;
          end else begin
            state_n = DACC;
            dwr_n   = dWEN;
            ren_n   = !dWEN;
            wen_n   = dWEN;
            addr_n  = daddr;
            store_n = dstore;
          end
        end
      end

      IACC, DACC: begin
        if (!req_live) begin
          state_n = IDLE;
          ren_n   = 1'b0;
          wen_n   = 1'b0;
          retry_n = '0;
        end else begin
          case (rs)
            ACCESS: begin
              ren_n = 1'b0;
              wen_n = 1'b0;
              if (state == IACC) begin
                iload_n = ramload;
                state_n = DONE_I;
              end else begin
                dload_n = ramload;
                state_n = DONE_D;
              end
            end
            ERROR: begin
              // Strobes drop for one cycle; the hold branch re-raises them.
              ren_n = 1'b0;
              wen_n = 1'b0;
              if (retry < RW'(RETRY_MAX)) begin
                retry_n = retry + RW'(1);
              end else begin
                err_n = 1'b1;
                if (state == IACC) begin
                  iload_n = '0;
                  state_n = DONE_I;
                end else begin
                  dload_n = '0;
                  state_n = DONE_D;
                end
              end
            end
            default: begin
              ren_n = (state == IACC) || !dwr;
              wen_n = (state == DACC) && dwr;
            end
          endcase
        end
      end

      DONE_I, DONE_D: begin
        ren_n   = 1'b0;
        wen_n   = 1'b0;
        retry_n = '0;
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
        ren_n   = 1'b0;
        wen_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      iload    <= '0;
      dload    <= '0;
      retry    <= '0;
      err      <= 1'b0;
      dwr      <= 1'b0;
    end else begin
      state    <= state_n;
      ramREN   <= ren_n;
      ramWEN   <= wen_n;
      ramaddr  <= addr_n;
      ramstore <= store_n;
      iload    <= iload_n;
      dload    <= dload_n;
      retry    <= retry_n;
      err      <= err_n;
      dwr      <= dwr_n;
    end
  end

endmodule
